// File: rtl/udiv_radix2_iter_pkg.sv
// udiv_radix2_iter_pkg: shared helpers for the radix-2 iterative divider.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package udiv_radix2_iter_pkg;

  // Width of a down-counter that must hold values 0 .. w-1.
  function automatic int udiv_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/unsigned_division_interface.sv
// unsigned_division_interface: request/result bundle between the div execution unit and the divider.
// Latency: n/a (wiring only).
// Backpressure: none; the requester must not pulse start while the divider is busy.
// Ports: start/dividend/divisor flow requester -> divider;
//        quotient/remainder/done/divisor_is_zero flow divider -> requester.
interface unsigned_division_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  done;
  logic                  divisor_is_zero;

  modport divider (
    input  start, dividend, divisor,
    output quotient, remainder, done, divisor_is_zero
  );

  modport requester (
    output start, dividend, divisor,
    input  quotient, remainder, done, divisor_is_zero
  );
endinterface

// File: rtl/udiv_radix2_iter_step.sv
// udiv_radix2_step: one restoring-division step (shift in a dividend bit, trial subtract, restore).
// Latency: combinational.
// Backpressure: none.
// Ports: r (partial remainder), q_msb (next dividend bit), divisor -> r_next, q_bit.
module udiv_radix2_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] r,
  input  logic                  q_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] r_next,
  output logic                  q_bit
);
  // Between steps the partial remainder is always < divisor, so its top bit
  // (bit W of the W+1-bit R) is always zero and is not carried around; the
  // full W+1 bits only exist here in the shifted value and trial difference.
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[DATA_WIDTH];
    r_next  = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/udiv_radix2_iter.sv
// udiv_radix2_iter: iterative radix-2 restoring unsigned divider with divide-by-zero and small-dividend fast paths.
// Latency: 1 cycle on fast paths, DATA_WIDTH cycles otherwise; results held until the next accepted start.
// Backpressure: none; start while busy is ignored.
// Ports: clk, rst (async active-high), div (divider modport: start/dividend/divisor in,
//        quotient/remainder/done/divisor_is_zero out).
module udiv_radix2_iter
  import udiv_radix2_iter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic                          clk,
  input logic                          rst,
  unsigned_division_interface.divider  div
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = udiv_cnt_width(W);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       r_q, r_d;       // partial remainder
  logic [W-1:0]       q_q, q_d;       // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]       dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       rem_q, rem_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [W-1:0]       step_r;
  logic               step_qbit;
  logic [W-1:0]       q_shift;

  udiv_radix2_step #(
    .DATA_WIDTH(W)
  ) u_step (
    .r       (r_q),
    .q_msb   (q_q[W-1]),
    .divisor (dvsr_q),
    .r_next  (step_r),
    .q_bit   (step_qbit)
  );

  assign q_shift = {q_q[W-2:0], step_qbit};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (div.start) begin
          dvsr_d = div.divisor;
          if (div.divisor == '0) begin
            quo_d  = '1;
            rem_d  = div.dividend;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dz_d = 1'b0;
            if (div.dividend < div.divisor) begin
              quo_d  = '0;
              rem_d  = div.dividend;
              done_d = 1'b1;
            end else begin
              state_d = BUSY;
              r_d     = '0;
              q_d     = div.dividend;
              cnt_d   = CNT_W'(W - 1);
            end
          end
        end
      end

      BUSY: begin
        r_d   = step_r;
        q_d   = q_shift;
        cnt_d = cnt_q - CNT_W'(1);
        // Results are published only from the last step so the previous
        // answer stays visible for the whole iteration.
        if (cnt_q == '0) begin
          quo_d   = q_shift;
          rem_d   = step_r;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign div.quotient        = quo_q;
  assign div.remainder       = rem_q;
  assign div.done            = done_q;
  assign div.divisor_is_zero = dz_q;
endmodule

// File: tb/tb_udiv_radix2_iter.sv
// tb_udiv_radix2_iter: directed and random checks of udiv_radix2_iter against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_udiv_radix2_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unsigned_division_interface #(.DATA_WIDTH(W)) div_if ();

  udiv_radix2_iter #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .div (div_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic plus RISC-V DIVU/REMU divide-by-zero rule.
  // lat = edges after the start-sampling edge until done is visible.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
      lat = (a < b) ? 0 : W;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    div_if.dividend = a;
    div_if.divisor  = b;
    div_if.start    = 1'b1;
    tick();
    div_if.start    = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (div_if.done !== 1'b1 && n < W + 8) begin
      tick();
      n++;
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er;
    logic edz;
    int elat, n;
    ref_div(a, b, eq, er, edz, elat);
    issue(a, b);
    wait_done(n);
    chk({tag, " latency"}, n, elat);
    chk({tag, " done"}, div_if.done, 1'b1);
    chk({tag, " quotient"}, div_if.quotient, eq);
    chk({tag, " remainder"}, div_if.remainder, er);
    chk({tag, " dz"}, div_if.divisor_is_zero, edz);
    tick();
    chk({tag, " done pulse"}, div_if.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, extra;
    logic [W-1:0] a, b;

    rst = 1'b1;
    div_if.start    = 1'b0;
    div_if.dividend = '0;
    div_if.divisor  = '0;
    #2;
    chk("reset quotient", div_if.quotient, 0);
    chk("reset remainder", div_if.remainder, 0);
    chk("reset done", div_if.done, 0);
    chk("reset dz", div_if.divisor_is_zero, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_div(32'd100, 32'd7, "100/7");

    run_div(32'hDEADBEEF, 32'd0, "div0");
    repeat (3) tick();
    chk("div0 held quotient", div_if.quotient, 32'hFFFFFFFF);
    chk("div0 held remainder", div_if.remainder, 32'hDEADBEEF);
    chk("div0 held dz", div_if.divisor_is_zero, 1'b1);

    run_div(32'd5, 32'd9, "5/9");
    run_div(32'hFFFFFFFF, 32'd1, "max/1");

    // Back-to-back: new start issued in the done cycle of the previous one.
    issue(32'h80000000, 32'd3);
    wait_done(n);
    chk("b2b first latency", n, W);
    chk("b2b first quotient", div_if.quotient, 32'h2AAAAAAA);
    chk("b2b first remainder", div_if.remainder, 32'd2);
    div_if.dividend = 32'd10;
    div_if.divisor  = 32'd0;
    div_if.start    = 1'b1;
    tick();
    div_if.start    = 1'b0;
    chk("b2b second done", div_if.done, 1'b1);
    chk("b2b second quotient", div_if.quotient, 32'hFFFFFFFF);
    chk("b2b second remainder", div_if.remainder, 32'd10);
    chk("b2b second dz", div_if.divisor_is_zero, 1'b1);
    tick();
    chk("b2b done pulse", div_if.done, 1'b0);

    // Start while busy must be ignored.
    issue(32'd1000, 32'd10);
    repeat (4) tick();
    div_if.dividend = 32'd50;
    div_if.divisor  = 32'd6;
    div_if.start    = 1'b1;
    tick();
    div_if.start    = 1'b0;
    wait_done(n);
    chk("busy-start latency", n + 5, W);
    chk("busy-start quotient", div_if.quotient, 32'd100);
    chk("busy-start remainder", div_if.remainder, 32'd0);
    extra = 0;
    repeat (40) begin
      tick();
      if (div_if.done === 1'b1) extra++;
    end
    chk("busy-start extra done", extra, 0);

    // Reset in the middle of a normal divide.
    issue(32'hFFFF0000, 32'd3);
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst quotient", div_if.quotient, 0);
    chk("midrst remainder", div_if.remainder, 0);
    chk("midrst done", div_if.done, 0);
    chk("midrst dz", div_if.divisor_is_zero, 0);
    tick();
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      tick();
      if (div_if.done === 1'b1) extra++;
    end
    chk("midrst no done", extra, 0);
    run_div(32'd9, 32'd4, "9/4");

    // Random operands, shaped to hit all three paths.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) a = a >> 20;
      run_div(a, b, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udiv_radix2_iter.md
# udiv_radix2_iter

Iterative radix-2 restoring unsigned divider, the responder for `unsigned_division_interface` (`divider` modport). It sits behind the core's div execution unit, which drives the `requester` side. The block computes quotient and remainder at one bit per clock, with single-cycle fast paths for divide-by-zero and dividend-smaller-than-divisor. It holds its results until the next request.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width. Legal values are 8 to 64.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `div.start`: input, 1 bit. Single-cycle request pulse.
- `div.dividend`: input, `DATA_WIDTH` bits. Sampled only on an accepted `start`.
- `div.divisor`: input, `DATA_WIDTH` bits. Sampled only on an accepted `start`.
- `div.quotient`: output, `DATA_WIDTH` bits. Valid from `done` onward; held until the next accepted `start`.
- `div.remainder`: output, `DATA_WIDTH` bits. Same validity as `quotient`.
- `div.done`: output, 1 bit. Registered single-cycle completion pulse.
- `div.divisor_is_zero`: output, 1 bit. Registered flag, valid and held with the results.

## Operation
- The FSM has two states, `IDLE` and `BUSY`. Reset state is `IDLE`.
- Reset value of every output is 0: `quotient`, `remainder`, `done`, `divisor_is_zero`.
- Accepting a request:
  - `start` is accepted only in `IDLE`.
  - `start` while `BUSY` is ignored, with no effect on state or operands.
  - The requester contract forbids `start` while busy; the block still tolerates it.
- On an accepted `start`, operands are latched and `divisor_is_zero` is cleared, except on the zero-divisor path below.
- Zero-divisor path (`divisor == 0`):
  - The FSM stays in `IDLE`.
  - Next edge: `quotient` = all ones, `remainder` = `dividend`, `divisor_is_zero` = 1, `done` = 1.
  - These are RISC-V DIVU/REMU semantics.
- Small-dividend path (`dividend < divisor`, `divisor != 0`): the FSM stays in `IDLE`. Next edge: `quotient` = 0, `remainder` = `dividend`, `done` = 1.
- Normal path: the FSM enters `BUSY`, loads partial remainder R = 0 (`DATA_WIDTH+1` bits) and quotient shift register Q = `dividend`, and sets the iteration counter to `DATA_WIDTH-1`.
- Each `BUSY` cycle performs one restoring step:
  - Compute T = {R[W-1:0], Q[W-1]} − {1'b0, divisor}, at `W+1` bits.
  - If T is non-negative (T[W] = 0): R ← T and Q ← {Q[W-2:0], 1}.
  - Otherwise: R ← {R[W-1:0], Q[W-1]} and Q ← {Q[W-2:0], 0}.
- When the counter is 0, the final step's results are written to `quotient`/`remainder`, `done` is set, and the FSM returns to `IDLE`.
- Back-to-back: `start` in the cycle `done` is high is accepted, because the FSM is already in `IDLE`. The results change on the following edge.
- Outputs are never modified while `BUSY`. The previous result stays visible until the final step.

## Timing
- Start-sampling edge is E0.
- Fast paths: `done` is high for the cycle after E0 (latency 1).
- Normal path:
  - Steps execute on edges E1 to E`DATA_WIDTH`.
  - `done` rises on edge E`DATA_WIDTH` and is high for exactly one cycle (latency `DATA_WIDTH`; 32 for the default).
- `done` is never high for two consecutive cycles unless a new `start` was accepted in the first of them and that request takes a fast path.
- Reset mid-operation: the FSM returns to `IDLE` and outputs go to 0 asynchronously. No `done` is produced for the aborted request.

## Structure
- No shared-package additions are needed. `DATA_WIDTH` is the only configuration; the state enum is local to the module.
- One combinational sub-module, `udiv_radix2_step`:
  - Inputs: `R`, `Q` MSB, `divisor`.
  - Outputs: next `R` and the quotient bit.
  - It isolates the `W+1`-bit subtract/restore so a later radix-4 variant can instantiate two of them.
- Counter width is `$clog2(DATA_WIDTH)`.

## Test plan
- 100 / 7 at W=32 → after 32 cycles `done`=1 for one cycle; `quotient`=14, `remainder`=2, `divisor_is_zero`=0.
- 0xDEADBEEF / 0 → next cycle `done`=1; `quotient`=0xFFFFFFFF, `remainder`=0xDEADBEEF, `divisor_is_zero`=1, held until the next start.
- 5 / 9 → next cycle `quotient`=0, `remainder`=5. Then 0xFFFFFFFF / 1 → after 32 cycles `quotient`=0xFFFFFFFF, `remainder`=0.
- Back-to-back: 0x80000000 / 3 then `start` in its `done` cycle with 10 / 0.
  - First result: `quotient`=0x2AAAAAAA, `remainder`=2.
  - Then, one cycle later: `quotient`=0xFFFFFFFF, `remainder`=10, `divisor_is_zero`=1.
- `start` with 50 / 6 pulsed at cycle 5 of a running 1000 / 10 → ignored. Result is `quotient`=100, `remainder`=0 at cycle 32, and no second `done`.
- Assert `rst` at cycle 10 of a normal divide → all outputs 0 immediately, no `done` within 40 cycles. A new 9 / 4 then gives `quotient`=2, `remainder`=1.
